// File: rtl/coolgirl_cfg_ctrl.sv
// coolgirl_cfg_ctrl: menu-facing $5000-$5FFF config register file with keyed flash-write unlock,
// lockout until reset, and a registered status readback at reg 7.
module coolgirl_cfg_ctrl #(
    parameter int          UNLOCK_TIMEOUT = 64,
    parameter logic [7:0]  KEY1           = 8'hA5,
    parameter logic [7:0]  KEY2           = 8'h5A
) (
    input  logic        m2,
    input  logic        rst_n,
    input  logic        romsel,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        wr_stb,
    input  logic        rd_stb,
    output logic [12:0] cpu_base,
    output logic [6:0]  prg_mask,
    output logic [4:0]  chr_mask,
    output logic [1:0]  sram_page,
    output logic [4:0]  mapper_sel,
    output logic        four_screen,
    output logic        sram_enabled,
    output logic        map_rom_on_6000,
    output logic        chr_write_enabled,
    output logic        prg_write_enabled,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_out_en
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_ARMED = 2'b01, S_UNLOCKED = 2'b10} state_t;
    localparam logic [7:0] TIMEOUT = 8'(UNLOCK_TIMEOUT);
    state_t      r_state, w_state_nx;
    logic [7:0]  r_cnt, w_cnt_nx;
    logic        r_prg_we, w_prg_we_nx;
    logic        r_lockout;
    logic [12:0] r_cpu_base;
    logic [6:0]  r_prg_mask;
    logic [4:0]  r_chr_mask, r_mapper_sel;
    logic [1:0]  r_sram_page;
    logic        r_four_screen, r_sram_en, r_map6000, r_chr_we;
    logic [7:0]  r_dout;
    logic        r_dout_en;
    logic        w_sel, w_hit, w_key, w_lock_set, w_rd;
    logic [2:0]  w_reg;
    assign w_sel      = romsel & (cpu_addr_in[14:12] == 3'b101);
    assign w_reg      = cpu_addr_in[2:0];
    assign w_hit      = wr_stb & w_sel & ~r_lockout;
    assign w_key      = w_hit & (w_reg == 3'd6);
    assign w_lock_set = w_hit & (w_reg == 3'd5) & cpu_data_in[7];
    assign w_rd       = rd_stb & ~wr_stb & w_sel & (w_reg == 3'd7);
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_prg_we_nx = r_prg_we;
        case (r_state)
            S_IDLE: if (w_key) begin
                if (cpu_data_in == KEY1) begin
                    w_state_nx = S_ARMED;
                    w_cnt_nx   = TIMEOUT;
                end else if (cpu_data_in == 8'h00) w_prg_we_nx = 1'b0;
            end
            S_ARMED: if (w_key) begin
                if (cpu_data_in == KEY2) begin
                    w_state_nx  = S_UNLOCKED;
                    w_prg_we_nx = 1'b1;
                end else if (cpu_data_in == KEY1) w_cnt_nx = TIMEOUT;
                else w_state_nx = S_IDLE;
            end else begin
                // Counter expiring to zero drops the window on this edge.
                w_cnt_nx   = r_cnt - 8'd1;
                w_state_nx = (r_cnt <= 8'd1) ? S_IDLE : S_ARMED;
            end
            S_UNLOCKED: if (w_key) begin
                if (cpu_data_in == 8'h00) begin
                    w_state_nx  = S_IDLE;
                    w_prg_we_nx = 1'b0;
                end else if (cpu_data_in == KEY1) begin
                    w_state_nx = S_ARMED;
                    w_cnt_nx   = TIMEOUT;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_lock_set) begin
            w_state_nx  = S_IDLE;
            w_cnt_nx    = 8'd0;
            w_prg_we_nx = 1'b0;
        end
    end
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_prg_we <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_prg_we <= w_prg_we_nx;
        end
    end
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_base    <= '0;
            r_prg_mask    <= '0;
            r_chr_mask    <= '0;
            r_mapper_sel  <= '0;
            r_sram_page   <= '0;
            r_four_screen <= 1'b0;
            r_sram_en     <= 1'b0;
            r_map6000     <= 1'b0;
            r_chr_we      <= 1'b0;
            r_lockout     <= 1'b0;
        end else if (w_hit) begin
            case (w_reg)
                3'd0: r_cpu_base[12:5] <= cpu_data_in;
                3'd1: r_cpu_base[4:0]  <= cpu_data_in[4:0];
                3'd2: r_prg_mask       <= cpu_data_in[6:0];
                3'd3: begin
                    r_chr_mask    <= cpu_data_in[4:0];
                    r_four_screen <= cpu_data_in[7];
                end
                3'd4: begin
                    r_mapper_sel <= cpu_data_in[4:0];
                    r_sram_page  <= cpu_data_in[7:6];
                end
                3'd5: begin
                    r_sram_en <= cpu_data_in[0];
                    r_map6000 <= cpu_data_in[1];
                    r_chr_we  <= cpu_data_in[2];
                    r_lockout <= cpu_data_in[7];
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_dout    <= 8'h00;
            r_dout_en <= 1'b0;
        end else begin
            r_dout    <= w_rd ? {r_lockout, r_prg_we, r_state, 4'b0000} : r_dout;
            r_dout_en <= w_rd;
        end
    end
    assign cpu_base          = r_cpu_base;
    assign prg_mask          = r_prg_mask;
    assign chr_mask          = r_chr_mask;
    assign sram_page         = r_sram_page;
    assign mapper_sel        = r_mapper_sel;
    assign four_screen       = r_four_screen;
    assign sram_enabled      = r_sram_en;
    assign map_rom_on_6000   = r_map6000;
    assign chr_write_enabled = r_chr_we;
    assign prg_write_enabled = r_prg_we;
    assign cpu_data_out      = r_dout;
    assign cpu_data_out_en   = r_dout_en;
endmodule

// File: tb/tb_coolgirl_cfg_ctrl.sv
// tb_coolgirl_cfg_ctrl: directed + random stimulus against a cycle-stamped reference model;
// config outputs checked every cycle, readbacks via a scoreboard queue.
module tb_coolgirl_cfg_ctrl;
    localparam int T = 64;
    localparam logic [7:0] K1 = 8'hA5, K2 = 8'h5A;
    logic m2 = 0, rst_n = 0, romsel = 1, wr_stb = 0, rd_stb = 0;
    logic [14:0] addr = 0;
    logic [7:0]  din = 0;
    logic [12:0] cpu_base;
    logic [6:0]  prg_mask;
    logic [4:0]  chr_mask, mapper_sel;
    logic [1:0]  sram_page;
    logic four_screen, sram_enabled, map_rom_on_6000, chr_write_enabled, prg_write_enabled;
    logic [7:0] cpu_data_out;
    logic cpu_data_out_en;
    coolgirl_cfg_ctrl #(.UNLOCK_TIMEOUT(T), .KEY1(K1), .KEY2(K2)) dut (
        .m2(m2), .rst_n(rst_n), .romsel(romsel), .cpu_addr_in(addr), .cpu_data_in(din),
        .wr_stb(wr_stb), .rd_stb(rd_stb), .cpu_base(cpu_base), .prg_mask(prg_mask),
        .chr_mask(chr_mask), .sram_page(sram_page), .mapper_sel(mapper_sel),
        .four_screen(four_screen), .sram_enabled(sram_enabled), .map_rom_on_6000(map_rom_on_6000),
        .chr_write_enabled(chr_write_enabled), .prg_write_enabled(prg_write_enabled),
        .cpu_data_out(cpu_data_out), .cpu_data_out_en(cpu_data_out_en));
    always #5 m2 = ~m2;
    int cyc = 0;
    always @(posedge m2) cyc++;
    int vecs = 0, fails = 0;
    logic [7:0] rq[$];
    logic [7:0] mb[0:5];
    bit m_lock, m_en;
    int m_st, m_arm;
    function automatic int eff(int e);
        return (m_st == 1 && e - m_arm > T) ? 0 : m_st;
    endfunction
    function automatic logic [36:0] exp_cfg();
        return {mb[0], mb[1][4:0], mb[2][6:0], mb[3][4:0], mb[4][7:6], mb[4][4:0], mb[3][7],
                mb[5][0], mb[5][1], mb[5][2], m_en};
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 6; i++) mb[i] = 8'h00;
        m_lock = 0; m_en = 0; m_st = 0; m_arm = 0;
        rq.delete();
    endtask
    task automatic model_write(int e, logic [14:0] a, logic [7:0] d);
        int r;
        r = int'(a[2:0]);
        if (r < 6) mb[r] = d;
        if (r == 5 && d[7]) begin
            m_lock = 1; m_en = 0; m_st = 0;
        end
        if (r == 6) begin
            m_st = eff(e);
            if (m_st == 0) begin
                if (d == K1) begin m_st = 1; m_arm = e; end
                else if (d == 8'h00) m_en = 0;
            end else if (m_st == 1) begin
                if (d == K2) begin m_st = 2; m_en = 1; end
                else if (d == K1) m_arm = e;
                else m_st = 0;
            end else begin
                if (d == 8'h00) begin m_st = 0; m_en = 0; end
                else if (d == K1) begin m_st = 1; m_arm = e; end
            end
        end
    endtask
    task automatic op(bit w, bit r, logic [14:0] a, logic [7:0] d, bit rs = 1);
        int e;
        bit sel;
        e = cyc + 1;
        sel = rs && a[14:12] == 3'b101;
        wr_stb = w; rd_stb = r; addr = a; din = d; romsel = rs;
        if (r && !w && sel && a[2:0] == 3'd7) rq.push_back({m_lock, m_en, 2'(eff(e)), 4'b0000});
        @(posedge m2);
        #1;
        if (w && sel && !m_lock) model_write(e, a, d);
        wr_stb = 0; rd_stb = 0; romsel = 1;
    endtask
    task automatic wr(logic [14:0] a, logic [7:0] d); op(1, 0, a, d); endtask
    task automatic rd(logic [14:0] a); op(0, 1, a, 8'h00); endtask
    task automatic idle(int n); for (int i = 0; i < n; i++) op(0, 0, 15'h0000, 8'h00); endtask
    task automatic do_reset();
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge m2);
        #1 rst_n = 1;
    endtask
    always @(negedge m2) begin
        logic [36:0] got;
        got = {cpu_base, prg_mask, chr_mask, sram_page, mapper_sel, four_screen, sram_enabled,
               map_rom_on_6000, chr_write_enabled, prg_write_enabled};
        vecs++;
        if (got !== exp_cfg()) begin
            fails++;
            $display("FAIL cfg @%0d: got %h expected %h", cyc, got, exp_cfg());
        end
        if (cpu_data_out_en === 1'b1) begin
            vecs++;
            if (rq.size() == 0) begin
                fails++;
                $display("FAIL readback @%0d: unexpected en, data %h expected no read", cyc, cpu_data_out);
            end else begin
                logic [7:0] x;
                x = rq.pop_front();
                if (cpu_data_out !== x) begin
                    fails++;
                    $display("FAIL readback @%0d: got %h expected %h", cyc, cpu_data_out, x);
                end
            end
        end
    end
    initial begin
        model_reset();
        repeat (2) @(posedge m2);
        #1 rst_n = 1;
        wr(15'h5000, 8'h9C); wr(15'h5002, 8'h33); wr(15'h5006, K1); idle(3);
        do_reset();
        rd(15'h5007); idle(1);
        wr(15'h5000, 8'h12); wr(15'h5001, 8'h1F); wr(15'h5002, 8'h7F);
        wr(15'h5003, 8'h85); wr(15'h5004, 8'hC3); wr(15'h5005, 8'h07); idle(1);
        wr(15'h5FF8, 8'h34); op(1, 0, 15'h5001, 8'h00, 0); idle(1);
        wr(15'h5006, K1); idle(9); wr(15'h5006, K2); rd(15'h5007);
        wr(15'h5006, 8'h00); rd(15'h5007); idle(1);
        wr(15'h5006, K1); idle(T - 1); wr(15'h5006, K2); rd(15'h5007); wr(15'h5006, 8'h00);
        wr(15'h5006, K1); idle(T); wr(15'h5006, K2); rd(15'h5007);
        wr(15'h5006, K1); wr(15'h5006, 8'h33); wr(15'h5006, K2); rd(15'h5007);
        wr(15'h5006, K1); wr(15'h5006, K2); wr(15'h5005, 8'h80); rd(15'h5007);
        for (int r = 0; r < 7; r++) wr(15'h5000 | 15'(r), r == 6 ? K1 : 8'hFF);
        wr(15'h5006, K2); rd(15'h5007);
        op(1, 1, 15'h5007, 8'h00); idle(2);
        rd(15'h5003); idle(1);
        do_reset();
        for (int i = 0; i < 700; i++) begin
            logic [14:0] a;
            logic [7:0] d;
            logic [2:0] top;
            top = ($urandom % 8 == 0) ? 3'($urandom) : 3'b101;
            a = {top, 9'($urandom), ($urandom % 2 == 0) ? 3'd6 : 3'($urandom)};
            case ($urandom % 5)
                0: d = K1;
                1: d = K2;
                2: d = 8'h00;
                default: d = 8'($urandom);
            endcase
            if (a[2:0] == 3'd5 && $urandom % 40 != 0) d[7] = 1'b0;
            if ($urandom % 4 == 0) op(0, 1, {3'b101, a[11:0]}, d, $urandom % 10 != 0);
            else op($urandom % 6 != 0, $urandom % 8 == 0, a, d, $urandom % 10 != 0);
            if ($urandom % 25 == 0) idle(int'($urandom_range(T - 2, T + 2)));
            if (i % 150 == 149) do_reset();
        end
        idle(3);
        vecs++;
        if (rq.size() != 0) begin
            fails++;
            $display("FAIL readback_drain: %0d pending expected 0", rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
